// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the 5-stage pipeline registers and the hazard/stall controller.
// The pipeline (master) drives the stage fields; the controller (slave) returns enables, selects and status.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       id_rn1;
  logic [3:0]       id_rn2;
  logic             id_uses_rn2;
  logic [3:0]       ex_rn1;
  logic [3:0]       ex_rn2;
  logic [3:0]       ex_wn;
  logic             ex_mr;
  logic             ex_enrw;
  logic [3:0]       m_wn;
  logic             m_mr;
  logic             m_mw;
  logic             m_enrw;
  logic [3:0]       wb_wn;
  logic             wb_enrw;
  logic             mem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_m_en;
  logic             m_wb_en;
  logic             id_ex_flush;
  logic             m_wb_flush;
  logic [1:0]       fa;
  logic [1:0]       fb;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] lu_count;

  modport master (
    output id_rn1, id_rn2, id_uses_rn2, ex_rn1, ex_rn2, ex_wn, ex_mr, ex_enrw,
           m_wn, m_mr, m_mw, m_enrw, wb_wn, wb_enrw, mem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en, id_ex_flush, m_wb_flush,
           fa, fb, mem_err, stall_cycles, lu_count
  );

  modport slave (
    input  id_rn1, id_rn2, id_uses_rn2, ex_rn1, ex_rn2, ex_wn, ex_mr, ex_enrw,
           m_wn, m_mr, m_mw, m_enrw, wb_wn, wb_enrw, mem_ready,
    output pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en, id_ex_flush, m_wb_flush,
           fa, fb, mem_err, stall_cycles, lu_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller: forwarding selects, load-use bubbles, memory-wait freeze
// with a sticky watchdog error, and saturating stall / bubble performance counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input logic              clk,
  input logic              rst_n,
  pipe_hazard_ctrl_if.slave pipe
);

  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] ERR = 1'b1;

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);

  logic [0:0]        state_q, state_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0]  luCnt_q, luCnt_d;

  logic memBusy;
  logic loadUse;
  logic frozen;
  logic bubble;
  logic pcEn;

  // EX_M result wins over WB data; a load in EX_M has no result yet, so it never forwards.
  function automatic logic [1:0] fwdSel(
    input logic [3:0] rn,
    input logic       mEnrw,
    input logic       mMr,
    input logic [3:0] mWn,
    input logic       wbEnrw,
    input logic [3:0] wbWn
  );
    if (mEnrw && !mMr && (mWn == rn)) begin
      return 2'b10;
    end else if (wbEnrw && (wbWn == rn)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  assign memBusy = (pipe.m_mr | pipe.m_mw) & ~pipe.mem_ready;
  assign loadUse = pipe.ex_mr & pipe.ex_enrw &
                   ((pipe.ex_wn == pipe.id_rn1) |
                    (pipe.id_uses_rn2 & (pipe.ex_wn == pipe.id_rn2)));

  // A memory stall or watchdog error outranks the load-use bubble.
  assign frozen = (state_q == ERR) | memBusy;
  assign bubble = ~frozen & loadUse;
  assign pcEn   = ~frozen & ~loadUse;

  assign pipe.pc_en       = pcEn;
  assign pipe.if_id_en    = pcEn;
  assign pipe.id_ex_en    = ~frozen;
  assign pipe.ex_m_en     = ~frozen;
  assign pipe.m_wb_en     = ~frozen;
  assign pipe.id_ex_flush = bubble;
  assign pipe.m_wb_flush  = frozen;

  assign pipe.fa = fwdSel(pipe.ex_rn1, pipe.m_enrw, pipe.m_mr, pipe.m_wn, pipe.wb_enrw, pipe.wb_wn);
  assign pipe.fb = fwdSel(pipe.ex_rn2, pipe.m_enrw, pipe.m_mr, pipe.m_wn, pipe.wb_enrw, pipe.wb_wn);

  assign pipe.mem_err      = (state_q == ERR);
  assign pipe.stall_cycles = stallCnt_q;
  assign pipe.lu_count     = luCnt_q;

  // The MEM_TIMEOUT-th consecutive busy cycle is the last one spent in RUN.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    if (state_q == RUN) begin
      if (memBusy) begin
        if (waitCnt_q == WAIT_MAX) begin
          state_d = ERR;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end else begin
        waitCnt_d = '0;
      end
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    luCnt_d    = luCnt_q;
    if (!pcEn && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
    if (bubble && (luCnt_q != '1)) begin
      luCnt_d = luCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      waitCnt_q  <= '0;
      stallCnt_q <= '0;
      luCnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      stallCnt_q <= stallCnt_d;
      luCnt_q    <= luCnt_d;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage pipeline (IF_ID, ID_EX, EX_M, M_WB).
- Generates per-stage write enables and bubble-insert controls.
- Generates the EX-stage forwarding selects.
- Detects load-use hazards.
- Stalls the whole pipeline while the data memory is not ready, with a watchdog that latches a sticky error.
- Sits beside the pipeline registers; the datapath consumes its enables and selects directly.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum consecutive memory-wait cycles before error (≥2).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rn1, id_rn2  in  4  source register numbers of the instruction in ID (IF_ID).
- id_uses_rn2  in  1  ID instruction reads RN2.
- ex_rn1, ex_rn2, ex_wn  in  4  ID_EX register fields.
- ex_mr, ex_enrw  in  1  ID_EX memory-read / register-write controls.
- m_wn  in  4  EX_M destination.
- m_mr, m_mw, m_enrw  in  1  EX_M controls.
- wb_wn  in  4  M_WB destination.
- wb_enrw  in  1  M_WB register-write.
- mem_ready  in  1  data memory completes the access presented this cycle.
- pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en  out  1  stage register load enables.
- id_ex_flush  out  1  load zeros into ID_EX control fields (bubble).
- m_wb_flush  out  1  load zeros into M_WB control fields.
- fa, fb  out  2  ALU operand A/B select: 00 register file, 10 EX_M ALU result, 01 WB data.
- mem_err  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.
- lu_count  out  CNT_W  saturating count of load-use bubbles.

## Operation
- All 16 registers are ordinary; R0 is not hardwired.
- Forwarding (combinational):
  - fa = 10 if m_enrw & ~m_mr & m_wn==ex_rn1.
  - Otherwise fa = 01 if wb_enrw & wb_wn==ex_rn1.
  - Otherwise fa = 00.
  - fb is identical using ex_rn2.
  - EX_M has priority over M_WB.
- mem_busy = (m_mr | m_mw) & ~mem_ready.
- Load-use hazard: lu = ex_mr & ex_enrw & (ex_wn==id_rn1 | (id_uses_rn2 & ex_wn==id_rn2)).
- Enable priority, highest first:
  1. state ERR or mem_busy: all five enables 0, id_ex_flush=0, m_wb_flush=1.
  2. lu: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_m_en=1, m_wb_en=1, m_wb_flush=0.
  3. Otherwise: all enables 1, both flushes 0.
- FSM states:
  - RUN: if mem_busy & wait_cnt==MEM_TIMEOUT-1, go to ERR.
  - ERR: absorbing; left only by reset.
- wait_cnt (internal):
  - Increments each cycle mem_busy is 1 in RUN.
  - Clears to 0 in any RUN cycle where mem_busy is 0.
- mem_err = (state==ERR), registered.
- Counters:
  - stall_cycles increments on any cycle where pc_en==0.
  - lu_count increments on cycles where case 2 is selected.
  - Both saturate at all-ones.

## Timing
- Enables, flushes, fa and fb are combinational from the current inputs and state; zero latency.
- Counters, wait_cnt and mem_err update on the rising clk edge.
- Reset (rst_n low, asynchronous, at any time including mid-wait or in ERR):
  - State RUN, wait_cnt=0, mem_err=0, stall_cycles=0, lu_count=0.
  - With the pipeline registers zeroed, the outputs are: all enables 1, flushes 0, fa=fb=00.
- A load-use hazard lasts exactly one cycle: after the bubble, ex_mr=0.
- Memory wait of N cycles (N < MEM_TIMEOUT):
  - Pipeline frozen for exactly N cycles.
  - Advances in the first cycle mem_ready=1.
- Error timing: the MEM_TIMEOUT-th consecutive busy cycle is the last RUN cycle. mem_err rises on the next edge; the pipeline stays frozen even if mem_ready later rises.
- Simultaneous lu and mem_busy: memory stall wins. No bubble is inserted and lu_count does not increment. The hazard is re-evaluated once memory is ready.

## Test plan
- Reset mid-operation:
  - Stimulus: drive mem_busy 3 cycles with MEM_TIMEOUT=4, then pulse rst_n low asynchronously.
  - Response: wait_cnt, counters and mem_err return to 0 immediately. Two further busy cycles do not raise mem_err.
- Forwarding:
  - Stimulus: ex_rn1=3, m_wn=3, m_enrw=1, wb_wn=3, wb_enrw=1.
  - Response: fa=10.
  - Then m_enrw=0 → fa=01. Then m_mr=1 with m_enrw=1 → fa=01. ex_rn2=7 with no match → fb=00.
- Load-use:
  - Stimulus: ex_mr=1, ex_enrw=1, ex_wn=5, id_rn2=5, id_uses_rn2=1.
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1. lu_count 0→1, stall_cycles 0→1.
  - Repeat with id_uses_rn2=0 → no stall.
- Memory wait:
  - Stimulus: m_mr=1, mem_ready=0 for 3 cycles, then 1.
  - Response: all enables 0 and m_wb_flush=1 for 3 cycles; normal in the 4th. stall_cycles=3, mem_err=0.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, m_mw=1, mem_ready=0 held.
  - Response: mem_err=1 after the 4th busy edge. Enables stay 0 after mem_ready=1; only rst_n clears.
- Simultaneous hazards:
  - Stimulus: lu conditions plus m_mr=1, mem_ready=0 for 2 cycles.
  - Response: id_ex_flush=0 and lu_count unchanged during the wait. In the cycle after mem_ready=1, the bubble is inserted and lu_count=1.
